// File: rtl/jelly_img_xy_ss_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// jelly_img_xy_ss_arbiter_pkg
// Shared helpers for the XY sum-of-squares arbiter. No types are shared; every
// width is derived from module parameters. The only content is the tag-width
// helper, so the top and the arbiter derive SEL_WIDTH the same way.
// ---------------------------------------------------------------------------
package jelly_img_xy_ss_arbiter_pkg;

   // Tag width for NUM requesters. A single requester pair still gets a
   // 1-bit tag so that no zero-width vectors appear.
   function automatic int sel_width(input int num);
      return (num <= 2) ? 1 : $clog2(num);
   endfunction

endpackage

// File: rtl/jelly_rr_arbiter.sv
// ---------------------------------------------------------------------------
// jelly_rr_arbiter
// Round-robin arbiter. It searches request[] starting one past the last
// granted index and wraps modulo NUM. The first requesting index wins.
// The grant is combinational. The last pointer moves only when the caller
// strobes advance, which means the grant was actually taken.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   request      : per-requester request vector
//   advance      : acceptance strobe; latches index into the last pointer
//   grant        : one-hot grant (all zero when nothing requests)
//   index        : encoded grant index (0 when nothing requests)
// ---------------------------------------------------------------------------
module jelly_rr_arbiter
   import jelly_img_xy_ss_arbiter_pkg::*;
#(
   parameter int NUM       = 4,
   parameter int SEL_WIDTH = sel_width(NUM)
)(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM-1:0]       request,
   input  logic                 advance,
   output logic [NUM-1:0]       grant,
   output logic [SEL_WIDTH-1:0] index
);

   // One extra bit holds last + k before the wrap. The maximum is 2*NUM-1.
   localparam int JW = SEL_WIDTH + 1;

   logic [SEL_WIDTH-1:0] last;

   always_comb begin
      logic [JW-1:0]        j;
      logic [SEL_WIDTH-1:0] sel;
      logic                 found;
      grant = '0;
      index = '0;
      found = 1'b0;
      j     = '0;
      sel   = '0;
      for (int k = 1; k <= NUM; k++) begin
         j = {1'b0, last} + JW'(k);
         if (j >= JW'(NUM)) begin
            j = j - JW'(NUM);
         end
         sel = j[SEL_WIDTH-1:0];
         if (!found && request[sel]) begin
            grant[sel] = 1'b1;
            index      = sel;
            found      = 1'b1;
         end
      end
   end

   // After reset, last points at NUM-1. This gives requester 0 first priority.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last <= SEL_WIDTH'(NUM - 1);
      end else if (advance) begin
         last <= index;
      end
   end

endmodule

// File: rtl/jelly_img_xy_ss_arbiter.sv
// ---------------------------------------------------------------------------
// jelly_img_xy_ss_arbiter
// Shares one pipelined x^2 + y^2 datapath among NUM requesters. At most one
// requester is granted per cycle, chosen round-robin. Its operands travel
// down the pipe with a requester tag, and the result is written back into
// that requester's own output register.
//
//   st0 : x, y, tag              (loaded on acceptance)
//   st1 : xx = x*x, yy = y*y, tag
//   wb  : m_ss[tag] <= xx + yy, m_valid[tag] <= 1, inflight[tag] <= 0
//
// A request accepted on a cke-high edge is visible on m_valid/m_ss after the
// third cke-high edge, counting the acceptance edge. cke low freezes all
// state and masks s_ready.
//
// Ports:
//   clk, reset_n, cke : clock, async active-low reset, clock enable
//   s_x, s_y          : NUM packed signed operands, DATA_WIDTH each
//   s_valid / s_ready : request handshake; s_ready is one-hot or zero
//   m_ss              : NUM packed unsigned results, 2*DATA_WIDTH each
//   m_valid / m_ready : per-requester result handshake
// ---------------------------------------------------------------------------
module jelly_img_xy_ss_arbiter
   import jelly_img_xy_ss_arbiter_pkg::*;
#(
   parameter int NUM        = 4,
   parameter int DATA_WIDTH = 8,
   parameter int SEL_WIDTH  = sel_width(NUM)
)(
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      cke,

   input  logic [NUM*DATA_WIDTH-1:0] s_x,
   input  logic [NUM*DATA_WIDTH-1:0] s_y,
   input  logic [NUM-1:0]            s_valid,
   output logic [NUM-1:0]            s_ready,

   output logic [NUM*2*DATA_WIDTH-1:0] m_ss,
   output logic [NUM-1:0]              m_valid,
   input  logic [NUM-1:0]              m_ready
);

   localparam int PW = 2 * DATA_WIDTH;

   logic [NUM-1:0][DATA_WIDTH-1:0] x_arr;
   logic [NUM-1:0][DATA_WIDTH-1:0] y_arr;

   logic [NUM-1:0]       inflight;
   logic [NUM-1:0]       elig;
   logic [NUM-1:0]       grant;
   logic [SEL_WIDTH-1:0] grant_idx;
   logic                 accept;

   // vld_pipe[0] = st0 valid, vld_pipe[1] = st1 valid (write-back next edge)
   logic [1:0]                   vld_pipe;
   logic signed [DATA_WIDTH-1:0] st0_x;
   logic signed [DATA_WIDTH-1:0] st0_y;
   logic [SEL_WIDTH-1:0]         st0_tag;
   logic signed [PW-1:0]         st1_xx;
   logic signed [PW-1:0]         st1_yy;
   logic [SEL_WIDTH-1:0]         st1_tag;
   logic [PW-1:0]                wb_sum;
   logic [NUM-1:0]               wb_hit;

   logic [NUM-1:0][PW-1:0] ss_q;
   logic [NUM-1:0]         valid_q;

   assign x_arr   = s_x;
   assign y_arr   = s_y;
   assign m_ss    = ss_q;
   assign m_valid = valid_q;

   // A requester may compete only when it has nothing in the pipe and its
   // output slot is free, or is being freed this cycle. That guarantees that
   // a write-back never overwrites an unconsumed result.
   assign elig = s_valid & ~inflight & (~valid_q | m_ready);

   jelly_rr_arbiter #(
      .NUM       (NUM),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .request (elig),
      .advance (accept),
      .grant   (grant),
      .index   (grant_idx)
   );

   // The grant only includes requesters with s_valid high. Any s_ready bit
   // therefore marks an acceptance.
   assign s_ready = grant & {NUM{cke & reset_n}};
   assign accept  = |s_ready;

   // Both squares are non-negative. Their sum is at most 2^(PW-1), so it
   // fits in PW unsigned bits.
   assign wb_sum = $unsigned(st1_xx) + $unsigned(st1_yy);

   // Shared datapath
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe <= '0;
         st0_x    <= '0;
         st0_y    <= '0;
         st0_tag  <= '0;
         st1_xx   <= '0;
         st1_yy   <= '0;
         st1_tag  <= '0;
      end else if (cke) begin
         vld_pipe <= {vld_pipe[0], accept};
         if (accept) begin
            st0_x   <= x_arr[grant_idx];
            st0_y   <= y_arr[grant_idx];
            st0_tag <= grant_idx;
         end
         if (vld_pipe[0]) begin
            st1_xx  <= PW'(st0_x) * PW'(st0_x);
            st1_yy  <= PW'(st0_y) * PW'(st0_y);
            st1_tag <= st0_tag;
         end
      end
   end

   // Per-requester write-back decode
   generate
      for (genvar i = 0; i < NUM; i++) begin : g_lane
         assign wb_hit[i] = vld_pipe[1] && (st1_tag == SEL_WIDTH'(i));
      end
   endgenerate

   // Per-requester output registers and in-flight flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ss_q     <= '0;
         valid_q  <= '0;
         inflight <= '0;
      end else if (cke) begin
         for (int i = 0; i < NUM; i++) begin
            if (wb_hit[i]) begin
               ss_q[i]    <= wb_sum;
               valid_q[i] <= 1'b1;
            end else if (m_ready[i]) begin
               valid_q[i] <= 1'b0;
            end
            // Acceptance and write-back for the same requester are mutually
            // exclusive, because eligibility needs ~inflight.
            if (s_ready[i]) begin
               inflight[i] <= 1'b1;
            end else if (wb_hit[i]) begin
               inflight[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_jelly_img_xy_ss_arbiter.sv
module tb_jelly_img_xy_ss_arbiter;

   localparam int NUM = 4;
   localparam int DW  = 8;
   localparam int PW  = 2 * DW;

   logic                clk;
   logic                reset_n;
   logic                cke;
   logic [NUM*DW-1:0]   s_x;
   logic [NUM*DW-1:0]   s_y;
   logic [NUM-1:0]      s_valid;
   logic [NUM-1:0]      s_ready;
   logic [NUM*PW-1:0]   m_ss;
   logic [NUM-1:0]      m_valid;
   logic [NUM-1:0]      m_ready;

   int n_checks = 0;
   int n_fail   = 0;

   jelly_img_xy_ss_arbiter #(.NUM(NUM), .DATA_WIDTH(DW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .cke     (cke),
      .s_x     (s_x),
      .s_y     (s_y),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .m_ss    (m_ss),
      .m_valid (m_valid),
      .m_ready (m_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (scoreboard) ----------------
   // cnt[i]  : edges remaining until the result of requester i lands (0 = idle)
   // mv[i]   : result displayed and not yet consumed
   // ss_m[i] : value shown on m_ss[i]
   // q[i]    : expected sums of accepted requests waiting to land
   int              last_m;
   int              cnt  [NUM];
   bit              mv   [NUM];
   logic [PW-1:0]   ss_m [NUM];
   int              q    [NUM][$];
   bit              p_cke, p_rst;
   logic [NUM-1:0]  p_acc, p_mready;

   function automatic logic [NUM-1:0] pred_grant();
      logic [NUM-1:0] g;
      g = '0;
      for (int k = 1; k <= NUM; k++) begin
         int j;
         j = (last_m + k) % NUM;
         if (g == '0 && s_valid[j] && cnt[j] == 0 && (!mv[j] || m_ready[j]))
            g[j] = 1'b1;
      end
      return g;
   endfunction

   task automatic model_reset();
      last_m = NUM - 1;
      for (int i = 0; i < NUM; i++) begin
         cnt[i]  = 0;
         mv[i]   = 1'b0;
         ss_m[i] = '0;
         q[i].delete();
      end
   endtask

   task automatic model_step();
      logic [NUM-1:0]    g, mvv;
      logic [NUM*PW-1:0] ssv;
      if (!reset_n) begin
         model_reset();
      end else if (p_rst && p_cke) begin
         for (int i = 0; i < NUM; i++) begin
            bit wb;
            wb = 1'b0;
            if (cnt[i] > 0) begin
               cnt[i]--;
               if (cnt[i] == 0) wb = 1'b1;
            end
            if (wb) begin
               mv[i] = 1'b1;
               if (q[i].size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL scoreboard_underflow: lane %0d got empty queue expected entry", i);
               end else begin
                  ss_m[i] = PW'(q[i].pop_front());
               end
            end else if (p_mready[i]) begin
               mv[i] = 1'b0;
            end
         end
         for (int j = 0; j < NUM; j++) begin
            if (p_acc[j]) begin
               cnt[j] = 2;
               last_m = j;
            end
         end
      end
      g = pred_grant() & {NUM{cke & reset_n}};
      for (int i = 0; i < NUM; i++) begin
         mvv[i] = mv[i];
         ssv[i*PW +: PW] = ss_m[i];
      end
      chk("s_ready", 64'(s_ready), 64'(g));
      chk("m_valid", 64'(m_valid), 64'(mvv));
      chk("m_ss",    64'(m_ss),    64'(ssv));
      // record what the next edge will do
      p_rst    = reset_n;
      p_cke    = cke;
      p_mready = m_ready;
      p_acc    = g;
      for (int j = 0; j < NUM; j++) begin
         if (g[j]) begin
            int xv, yv;
            xv = int'($signed(s_x[j*DW +: DW]));
            yv = int'($signed(s_y[j*DW +: DW]));
            q[j].push_back(xv * xv + yv * yv);
         end
      end
   endtask

   initial begin
      model_reset();
      p_cke = 1'b0; p_rst = 1'b0; p_acc = '0; p_mready = '0;
      forever begin
         @(negedge clk);
         model_step();
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rand_data();
      s_x = $urandom;
      s_y = $urandom;
   endtask

   // Drive one request, hold until granted (bounded), then check result 3 edges later.
   task automatic send_chk(input int i, input int x, input int y, input logic [PW-1:0] exp);
      logic [DW-1:0] xs, ys;
      bit got;
      xs = DW'(x);
      ys = DW'(y);
      s_x[i*DW +: DW] = xs;
      s_y[i*DW +: DW] = ys;
      s_valid[i] = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
         #1;
         if (s_ready[i]) got = 1'b1;
         @(posedge clk);
         #1;
      end
      s_valid[i] = 1'b0;
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: lane %0d got no grant expected grant within 50 cycles", i);
      end else begin
         tick(2);
         chk("direct_valid", 64'(m_valid[i]), 64'd1);
         chk("direct_ss", 64'(m_ss[i*PW +: PW]), 64'(exp));
      end
      tick(2);
   endtask

   initial begin
      reset_n = 1'b0;
      cke     = 1'b1;
      s_x     = '0;
      s_y     = '0;
      s_valid = '0;
      m_ready = '1;
      tick(3);
      chk("reset_m_valid", 64'(m_valid), 64'd0);
      chk("reset_m_ss", 64'(m_ss), 64'd0);
      reset_n = 1'b1;
      tick(2);

      // single request: requester 2, x=3, y=-4
      s_x[2*DW +: DW] = 8'd3;
      s_y[2*DW +: DW] = 8'hFC;
      s_valid[2] = 1'b1;
      #1;
      chk("single_s_ready", 64'(s_ready), 64'b0100);
      tick(1);
      s_valid[2] = 1'b0;
      tick(2);
      chk("single_valid", 64'(m_valid[2]), 64'd1);
      chk("single_ss", 64'(m_ss[2*PW +: PW]), 64'd25);
      tick(1);
      chk("single_drop", 64'(m_valid[2]), 64'd0);
      tick(2);

      // extremes
      send_chk(0, -128, -128, 16'd32768);
      send_chk(1, 127, 0, 16'd16129);
      send_chk(3, 0, 0, 16'd0);

      // all requesters continuously valid
      s_valid = '1;
      for (int c = 0; c < 40; c++) begin
         rand_data();
         tick(1);
      end

      // backpressure on requester 1
      m_ready[1] = 1'b0;
      for (int c = 0; c < 20; c++) begin
         rand_data();
         tick(1);
      end
      m_ready[1] = 1'b1;
      tick(1);
      m_ready[1] = 1'b0;
      for (int c = 0; c < 8; c++) begin
         rand_data();
         tick(1);
      end
      m_ready[1] = 1'b1;
      tick(4);

      // cke low with requests in flight
      s_valid = '1;
      rand_data();
      tick(3);
      s_valid = '0;
      cke = 1'b0;
      tick(5);
      cke = 1'b1;
      tick(6);

      // random mix
      for (int c = 0; c < 400; c++) begin
         rand_data();
         s_valid = NUM'($urandom);
         m_ready = NUM'($urandom);
         cke = ($urandom_range(0, 7) != 0);
         tick(1);
      end
      cke = 1'b1;
      m_ready = '1;
      s_valid = '0;
      tick(6);

      // reset with requests in flight
      s_valid = '1;
      rand_data();
      tick(2);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_m_valid", 64'(m_valid), 64'd0);
      chk("async_rst_s_ready", 64'(s_ready), 64'd0);
      chk("async_rst_m_ss", 64'(m_ss), 64'd0);
      tick(2);
      reset_n = 1'b1;
      #1;
      chk("post_rst_first_grant", 64'(s_ready), 64'b0001);
      for (int c = 0; c < 20; c++) begin
         rand_data();
         tick(1);
      end
      s_valid = '0;
      tick(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
